// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's instruction-memory port, decode-side handshake and redirect inputs.
// master = fetch unit; slave = memory/decode environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;

  logic        PCsrc;
  logic        Jsrc;
  logic [31:0] PCtarget;
  logic [31:0] ALUresult;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, instr_pc4, op, funct3, funct7,
    input  instr_ready,
    input  PCsrc, Jsrc, PCtarget, ALUresult,
    output misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, instr_pc4, op, funct3, funct7,
    output instr_ready,
    output PCsrc, Jsrc, PCtarget, ALUresult,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch unit with a 2-entry {word, pc} buffer, redirect flush
// and discard of stale responses; a misaligned redirect halts fetch until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_run;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_rsp_pc;
  logic [1:0]  r_out;
  logic [1:0]  r_discard;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_misalign;
  logic [31:0] r_word [2];
  logic [31:0] r_pc   [2];

  logic        w_valid;
  logic        w_consume;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_misalign;
  logic [2:0]  w_inuse;
  logic        w_req;
  logic        w_xfer;
  logic        w_rsp;
  logic        w_push;
  logic        w_pop;
  logic        w_tail;
  logic [1:0]  w_out_next;
  logic [31:0] w_head_word;
  logic [31:0] w_head_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_misalign) w_state_next = HALT;
      HALT:    w_state_next = HALT;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    case (r_state)
      RUN:     w_run = 1'b1;
      default: w_run = 1'b0;
    endcase
  end

  assign w_valid    = reset_n & w_run & (r_count != 2'd0);
  assign w_consume  = w_valid & bus.instr_ready;
  assign w_redirect = w_consume & bus.PCsrc;
  assign w_target   = bus.Jsrc ? (bus.ALUresult & 32'hFFFF_FFFE) : bus.PCtarget;
  assign w_misalign = w_redirect & (w_target[1:0] != 2'b00);

  // Credits count this cycle's consume as already freed so streaming runs without bubbles.
  assign w_inuse    = {1'b0, r_out} + {1'b0, r_count} - {2'b00, w_consume};
  assign w_req      = reset_n & w_run & (w_inuse < 3'd2) & ~w_redirect;
  assign w_xfer     = w_req & bus.imem_ready;
  assign w_rsp      = bus.imem_rvalid & (r_out != 2'd0);
  assign w_push     = w_rsp & (r_discard == 2'd0) & ~w_redirect & w_run;
  assign w_pop      = w_consume & ~w_redirect;
  assign w_tail     = r_head ^ r_count[0];
  assign w_out_next = r_out + {1'b0, w_xfer} - {1'b0, w_rsp};

  // r_rsp_pc tracks the address of the next response that will be kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_out      <= 2'd0;
      r_discard  <= 2'd0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_out <= w_out_next;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_discard  <= w_out_next;
        r_count    <= 2'd0;
        r_head     <= 1'b0;
      end else begin
        if (w_xfer)                         r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)                         r_rsp_pc   <= r_rsp_pc + 32'd4;
        if (w_rsp && (r_discard != 2'd0))   r_discard  <= r_discard - 2'd1;
        if (w_pop)                          r_head     <= ~r_head;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
      if (w_misalign) r_misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_word[w_tail] <= bus.imem_rdata;
      r_pc[w_tail]   <= r_rsp_pc;
    end
  end

  assign w_head_word = r_word[r_head];
  assign w_head_pc   = r_pc[r_head];

  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_fetch_pc;
  assign bus.instr_valid  = w_valid;
  assign bus.instr        = w_head_word;
  assign bus.instr_pc     = w_head_pc;
  assign bus.instr_pc4    = w_head_pc + 32'd4;
  assign bus.op           = w_head_word[6:0];
  assign bus.funct3       = w_head_word[14:12];
  assign bus.funct7       = w_head_word[30];
  assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a driver models memory and decode, a monitor checks
// every consumed instruction against the queue of expected pcs.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] a;
    int          t;
  } memReq_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  memReq_t     memQ[$];
  logic [31:0] expQ[$];
  int          total = 0;
  int          bad = 0;
  int          cycleNo = 0;
  int          firstCons = -1;
  int          lastCons = -1;
  int          memLat = 1;
  int          startCycle = 0;
  bit          holdReady = 1'b0;
  bit          trigEn = 1'b0;
  bit          trigJ = 1'b0;
  logic [31:0] trigPc = 32'h0;
  logic [31:0] trigTarget = 32'h0;
  logic [31:0] trigAlu = 32'h0;
  logic [31:0] monExp;
  logic [31:0] monWord;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0] ^ 8'hC3, a[15:8], a[7:0], a[9:2] ^ 8'h33};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then record any accepted request.
  task automatic applyStimulus(input bit rstn);
    memReq_t r;
    @(negedge clk);
    cycleNo++;
    reset_n = rstn;
    if (!rstn) memQ.delete();
    bus.PCsrc     = 1'b0;
    bus.Jsrc      = 1'b0;
    bus.PCtarget  = 32'h0;
    bus.ALUresult = 32'h0;
    bus.instr_ready = !holdReady && (expQ.size() > 0);
    if (rstn && trigEn && bus.instr_ready && bus.instr_valid && bus.instr_pc == trigPc) begin
      bus.PCsrc     = 1'b1;
      bus.Jsrc      = trigJ;
      bus.PCtarget  = trigTarget;
      bus.ALUresult = trigAlu;
      trigEn = 1'b0;
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    if (rstn && memQ.size() > 0 && (cycleNo - memQ[0].t) >= memLat) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memWord(memQ[0].a);
      void'(memQ.pop_front());
    end
    #1;
    if (rstn && bus.imem_req && bus.imem_ready) begin
      r.a = bus.imem_addr;
      r.t = cycleNo;
      memQ.push_back(r);
    end
  endtask

  task automatic doReset();
    holdReady = 1'b0;
    trigEn = 1'b0;
    memLat = 1;
    expQ.delete();
    repeat (2) begin
      applyStimulus(1'b0);
      checkOutput("reset_req", {31'b0, bus.imem_req}, 32'd0);
      checkOutput("reset_valid", {31'b0, bus.instr_valid}, 32'd0);
    end
    firstCons = -1;
    lastCons = -1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      applyStimulus(1'b1);
      n++;
    end
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d left want 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic runToTrigger(input int budget);
    int n = 0;
    while (trigEn && n < budget) begin
      applyStimulus(1'b1);
      n++;
    end
    if (trigEn) begin
      total++;
      bad++;
      $display("[TB] FAIL trigger_timeout: got no redirect want redirect at %h", trigPc);
      trigEn = 1'b0;
    end
  endtask

  // Monitor: every consume must match the head of the expected-pc queue.
  always begin
    @(negedge clk);
    #2;
    if (reset_n === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_instr: got pc %h want none", bus.instr_pc);
      end else begin
        monExp  = expQ.pop_front();
        monWord = memWord(monExp);
        checkOutput("instr_pc", bus.instr_pc, monExp);
        checkOutput("instr", bus.instr, monWord);
        checkOutput("instr_pc4", bus.instr_pc4, monExp + 32'd4);
        checkOutput("decode_fields", {21'b0, bus.funct7, bus.funct3, bus.op},
                    {21'b0, monWord[30], monWord[14:12], monWord[6:0]});
        if (firstCons < 0) firstCons = cycleNo;
        lastCons = cycleNo;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.imem_ready  = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.PCsrc       = 1'b0;
    bus.Jsrc        = 1'b0;
    bus.PCtarget    = 32'h0;
    bus.ALUresult   = 32'h0;

    // Streaming: pcs 0..0x1C, first consume two cycles after release, then one per cycle.
    doReset();
    for (int i = 0; i < 8; i++) expQ.push_back(32'(i * 4));
    applyStimulus(1'b1);
    startCycle = cycleNo;
    checkOutput("first_req", {31'b0, bus.imem_req}, 32'd1);
    checkOutput("first_addr", bus.imem_addr, 32'h0);
    checkOutput("misalign_reset", {31'b0, bus.misalign_err}, 32'd0);
    drain(40);
    checkOutput("stream_first", 32'(firstCons), 32'(startCycle + 2));
    checkOutput("stream_last", 32'(lastCons), 32'(startCycle + 9));

    // Backpressure: buffer fills, fetch stops, order preserved on release.
    doReset();
    expQ = '{32'h0, 32'h4, 32'h8, 32'hC};
    holdReady = 1'b1;
    repeat (10) applyStimulus(1'b1);
    checkOutput("bp_valid", {31'b0, bus.instr_valid}, 32'd1);
    checkOutput("bp_head", bus.instr_pc, 32'h0);
    checkOutput("bp_req", {31'b0, bus.imem_req}, 32'd0);
    checkOutput("bp_inflight", 32'(memQ.size()), 32'd0);
    holdReady = 1'b0;
    drain(30);

    // Branch taken at 0x10 to 0x100; the response arriving with the redirect is dropped.
    doReset();
    expQ = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h104, 32'h108};
    trigPc = 32'h10; trigJ = 1'b0; trigTarget = 32'h100; trigAlu = 32'h0;
    trigEn = 1'b1;
    runToTrigger(30);
    applyStimulus(1'b1);
    checkOutput("br_req", {31'b0, bus.imem_req}, 32'd1);
    checkOutput("br_addr", bus.imem_addr, 32'h100);
    drain(30);

    // jalr with slow memory: a stale response arrives after the redirect and is discarded.
    doReset();
    memLat = 2;
    expQ = '{32'h0, 32'h4, 32'h204, 32'h208, 32'h20C};
    trigPc = 32'h4; trigJ = 1'b1; trigTarget = 32'h999; trigAlu = 32'h205;
    trigEn = 1'b1;
    runToTrigger(30);
    applyStimulus(1'b1);
    checkOutput("jalr_req", {31'b0, bus.imem_req}, 32'd1);
    checkOutput("jalr_addr", bus.imem_addr, 32'h204);
    checkOutput("jalr_misalign", {31'b0, bus.misalign_err}, 32'd0);
    drain(40);

    // Misaligned redirect halts until reset.
    doReset();
    expQ = '{32'h0, 32'h4};
    trigPc = 32'h4; trigJ = 1'b0; trigTarget = 32'h102; trigAlu = 32'h0;
    trigEn = 1'b1;
    runToTrigger(30);
    repeat (4) begin
      applyStimulus(1'b1);
      checkOutput("mis_err", {31'b0, bus.misalign_err}, 32'd1);
      checkOutput("mis_req", {31'b0, bus.imem_req}, 32'd0);
      checkOutput("mis_valid", {31'b0, bus.instr_valid}, 32'd0);
    end
    doReset();
    applyStimulus(1'b1);
    checkOutput("mis_clear", {31'b0, bus.misalign_err}, 32'd0);
    checkOutput("mis_restart_req", {31'b0, bus.imem_req}, 32'd1);
    checkOutput("mis_restart_addr", bus.imem_addr, 32'h0);

    // Address wrap: fetch continues from 0xFFFF_FFFC to 0.
    doReset();
    expQ = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    trigPc = 32'h0; trigJ = 1'b0; trigTarget = 32'hFFFF_FFF8; trigAlu = 32'h0;
    trigEn = 1'b1;
    drain(40);
    checkOutput("wrap_misalign", {31'b0, bus.misalign_err}, 32'd0);

    // Reset mid-stream with a full buffer.
    doReset();
    holdReady = 1'b1;
    repeat (6) applyStimulus(1'b1);
    checkOutput("mid_full_valid", {31'b0, bus.instr_valid}, 32'd1);
    checkOutput("mid_full_head", bus.instr_pc, 32'h0);
    applyStimulus(1'b0);
    checkOutput("mid_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    checkOutput("mid_rst_req", {31'b0, bus.imem_req}, 32'd0);
    applyStimulus(1'b1);
    checkOutput("mid_after_valid", {31'b0, bus.instr_valid}, 32'd0);
    checkOutput("mid_after_req", {31'b0, bus.imem_req}, 32'd1);
    checkOutput("mid_after_addr", bus.imem_addr, 32'h0);
    holdReady = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
